// File: rtl/jtcop_pkg.sv
// Shared definitions for the object buffer: object RAM address width and
// the DMA state encoding.
package jtcop_pkg;
  localparam int OBJ_AW = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITVB = 2'd1,
    COPY   = 2'd2
  } obj_st_t;
endpackage

// File: rtl/jtframe_dual_ram.sv
// Generic true dual-port RAM with byte-lane write enables and registered reads.
// Reads are read-before-write on both ports: the memory array updates through
// non-blocking assignments, so a same-edge read sees the previous contents.
// Read registers are cleared by rst. The array itself is never cleared.
// Ports: clk, rst; per port x in {a,b}: addr_x, data_x, we_x (one bit per byte), q_x.
module jtframe_dual_ram #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   addr_a,
  input  logic [DW-1:0]   data_a,
  input  logic [DW/8-1:0] we_a,
  output logic [DW-1:0]   q_a,
  input  logic [AW-1:0]   addr_b,
  input  logic [DW-1:0]   data_b,
  input  logic [DW/8-1:0] we_b,
  output logic [DW-1:0]   q_b
);
  localparam int NB = DW / 8;

  logic [DW-1:0] mem [0:2**AW-1];

  // Both write ports share one process. Port b wins a same-address collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we_a[i]) mem[addr_a][i*8 +: 8] <= data_a[i*8 +: 8];
      if (we_b[i]) mem[addr_b][i*8 +: 8] <= data_b[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_a <= '0;
    else     q_a <= mem[addr_a];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_b <= '0;
    else     q_b <= mem[addr_b];
  end
endmodule

// File: rtl/jtcop_obj_buffer.sv
// Object RAM plus sprite-list DMA buffer.
// The CPU owns a source RAM. A rising edge on obj_copy snapshots the whole
// source RAM into a display RAM read by the renderer. The copy can start
// immediately or wait for the next VBLANK start when mixpsel is set.
// Ports:
//   clk, rst                         clock, async active-high reset
//   obj_cs, cpu_addr, cpu_dout,
//   UDSWn, LDSWn, obj_dout           CPU side: byte writes, registered read
//   obj_copy, mixpsel, LVBL          copy request, defer select, vblank (low)
//   dma_busy                         copy pending or running
//   rd_addr, rd_data                 renderer side, 1-clock read latency
module jtcop_obj_buffer
  import jtcop_pkg::*;
#(
  parameter int AW       = OBJ_AW,
  parameter bit DEFER_VB = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          obj_cs,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_dout,
  input  logic          UDSWn,
  input  logic          LDSWn,
  output logic [15:0]   obj_dout,
  input  logic          obj_copy,
  input  logic          mixpsel,
  input  logic          LVBL,
  output logic          dma_busy,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);
  obj_st_t       st, st_nx;
  logic          obj_copy_l, LVBL_l;
  logic          req, vb_start;
  // Extra MSB flags that every source word has been read. The tail
  // cycle then only drains the final write.
  logic [AW:0]   src_cnt;
  logic [AW-1:0] dst;
  logic          rd_en, wr_en, last_wr;
  logic [15:0]   src_q, disp_unused;

  assign req      = obj_copy & ~obj_copy_l;
  assign vb_start = LVBL_l & ~LVBL;
  assign last_wr  = wr_en & (&dst);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  // Next state. Requests outside IDLE are dropped, not queued.
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (req) st_nx = (mixpsel && DEFER_VB) ? WAITVB : COPY;
      WAITVB:  if (vb_start) st_nx = COPY;
      COPY:    if (last_wr) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    dma_busy = 1'b0;
    rd_en    = 1'b0;
    case (st)
      WAITVB: dma_busy = 1'b1;
      COPY: begin
        dma_busy = 1'b1;
        rd_en    = ~src_cnt[AW];
      end
      default: ;
    endcase
  end

  // Edge detectors, read counter and the one-stage write pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obj_copy_l <= 1'b0;
      LVBL_l     <= 1'b0;
      src_cnt    <= '0;
      dst        <= '0;
      wr_en      <= 1'b0;
    end else begin
      obj_copy_l <= obj_copy;
      LVBL_l     <= LVBL;
      wr_en      <= rd_en;
      dst        <= src_cnt[AW-1:0];
      if (st != COPY) src_cnt <= '0;
      else if (rd_en) src_cnt <= src_cnt + 1'b1;
    end
  end

  jtframe_dual_ram #(.DW(16), .AW(AW)) u_src (
    .clk    (clk),
    .rst    (rst),
    .addr_a (cpu_addr),
    .data_a (cpu_dout),
    .we_a   ({obj_cs & ~UDSWn, obj_cs & ~LDSWn}),
    .q_a    (obj_dout),
    .addr_b (src_cnt[AW-1:0]),
    .data_b (16'd0),
    .we_b   (2'b00),
    .q_b    (src_q)
  );

  jtframe_dual_ram #(.DW(16), .AW(AW)) u_disp (
    .clk    (clk),
    .rst    (rst),
    .addr_a (dst),
    .data_a (src_q),
    .we_a   ({2{wr_en}}),
    .q_a    (disp_unused),
    .addr_b (rd_addr),
    .data_b (16'd0),
    .we_b   (2'b00),
    .q_b    (rd_data)
  );
endmodule
